// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3, one bit per clock)
// producing four packed BCD digits and a leading-zero blank mask.
//
// state   | meaning
// IDLE    | waiting for start; captures bin_in on acceptance
// CONVERT | one adjust-and-shift step per cycle, busy=1
// FINISH  | done=1 for one cycle with fresh bcd_out/blank_mask
module bin_to_bcd_seq #(
  parameter int IN_WIDTH = 8
) (
  input  logic                Clk_signal,
  input  logic                Reset,
  input  logic                start,
  input  logic [IN_WIDTH-1:0] bin_in,
  output logic                busy,
  output logic                done,
  output logic [15:0]         bcd_out,
  output logic [3:0]          blank_mask
);

  localparam int CW = $clog2(IN_WIDTH + 1);

  typedef enum logic [1:0] {IDLE, CONVERT, FINISH} state_t;

  state_t               state, state_nxt;
  logic [IN_WIDTH-1:0]  shift_reg;
  logic [15:0]          scratch;
  logic [CW-1:0]        cnt;
  logic [15:0]          adj;
  logic [15+IN_WIDTH:0] shifted;
  logic [15:0]          scratch_nxt;
  logic [IN_WIDTH-1:0]  shift_nxt;
  logic                 last_step;

  function automatic logic [3:0] mask_of(input logic [15:0] d);
    logic [3:0] m;
    m[3] = (d[15:12] == 4'd0);
    m[2] = m[3] & (d[11:8] == 4'd0);
    m[1] = m[2] & (d[7:4] == 4'd0);
    m[0] = 1'b0;
    return m;
  endfunction

  // Per-digit add-3 correction, no carry between digits
  always_comb begin
    adj = scratch;
    for (int i = 0; i < 4; i++) begin
      if (scratch[4*i +: 4] >= 4'd5)
        adj[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
    end
    shifted     = {adj, shift_reg} << 1;
    scratch_nxt = shifted[15+IN_WIDTH:IN_WIDTH];
    shift_nxt   = shifted[IN_WIDTH-1:0];
    last_step   = (cnt == CW'(1));
  end

  always_ff @(posedge Clk_signal) begin
    if (Reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = CONVERT;
      CONVERT: if (last_step) state_nxt = FINISH;
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == CONVERT);
    done = (state == FINISH);
  end

  always_ff @(posedge Clk_signal) begin
    if (Reset) begin
      shift_reg  <= '0;
      scratch    <= '0;
      cnt        <= '0;
      bcd_out    <= 16'h0000;
      blank_mask <= 4'b1110;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            shift_reg <= bin_in;
            scratch   <= '0;
            cnt       <= CW'(IN_WIDTH);
          end
        end
        CONVERT: begin
          scratch   <= scratch_nxt;
          shift_reg <= shift_nxt;
          cnt       <= cnt - CW'(1);
          if (last_step) begin
            bcd_out    <= scratch_nxt;
            blank_mask <= mask_of(scratch_nxt);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Directed bench for bin_to_bcd_seq: 8-bit and 13-bit instances, vector
// table plus hand-written start-ignore, mid-conversion reset and sweep cases.
module tb_bin_to_bcd_seq;

  logic        clk = 1'b0;
  logic        Reset;
  logic        start8, start13;
  logic [7:0]  bin8;
  logic [12:0] bin13;
  logic        busy8, done8, busy13, done13;
  logic [15:0] bcd8, bcd13;
  logic [3:0]  mask8, mask13;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  bin_to_bcd_seq #(.IN_WIDTH(8)) dut8 (
    .Clk_signal(clk), .Reset(Reset), .start(start8), .bin_in(bin8),
    .busy(busy8), .done(done8), .bcd_out(bcd8), .blank_mask(mask8));

  bin_to_bcd_seq #(.IN_WIDTH(13)) dut13 (
    .Clk_signal(clk), .Reset(Reset), .start(start13), .bin_in(bin13),
    .busy(busy13), .done(done13), .bcd_out(bcd13), .blank_mask(mask13));

  typedef struct {
    int          w;
    logic [12:0] v;
    logic [15:0] bcd;
    logic [3:0]  mask;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic busy_of(input int w);
    return (w == 8) ? busy8 : busy13;
  endfunction
  function automatic logic done_of(input int w);
    return (w == 8) ? done8 : done13;
  endfunction
  function automatic logic [15:0] bcd_of(input int w);
    return (w == 8) ? bcd8 : bcd13;
  endfunction
  function automatic logic [3:0] mask_of(input int w);
    return (w == 8) ? mask8 : mask13;
  endfunction

  // Called at the sample point of an IDLE cycle; returns at the IDLE cycle after done.
  task automatic run(input int w, input logic [12:0] v, input logic [15:0] eb,
                     input logic [3:0] em, output int done_at);
    done_at = -1;
    if (w == 8) begin start8 = 1'b1; bin8 = v[7:0]; end
    else        begin start13 = 1'b1; bin13 = v; end
    for (int k = 1; k <= w + 2; k++) begin
      step();
      start8  = 1'b0;
      start13 = 1'b0;
      if (k <= w) begin
        chk("busy_in_convert", 32'(busy_of(w)), 32'd1);
        chk("no_done_in_convert", 32'(done_of(w)), 32'd0);
      end else if (k == w + 1) begin
        chk("done_pulse", 32'(done_of(w)), 32'd1);
        chk("busy_in_finish", 32'(busy_of(w)), 32'd0);
        chk("bcd_out", 32'(bcd_of(w)), 32'(eb));
        chk("blank_mask", 32'(mask_of(w)), 32'(em));
        done_at = cyc;
      end else begin
        chk("done_one_cycle", 32'(done_of(w)), 32'd0);
        chk("busy_after_done", 32'(busy_of(w)), 32'd0);
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int d, prev;
    int d0, d1, d2, d3;
    logic [15:0] rb;
    logic [3:0]  rm;

    vecs[0]  = '{8,  13'd0,    16'h0000, 4'b1110};
    vecs[1]  = '{8,  13'd255,  16'h0255, 4'b1000};
    vecs[2]  = '{8,  13'd99,   16'h0099, 4'b1100};
    vecs[3]  = '{8,  13'd100,  16'h0100, 4'b1000};
    vecs[4]  = '{8,  13'd5,    16'h0005, 4'b1110};
    vecs[5]  = '{8,  13'd10,   16'h0010, 4'b1100};
    vecs[6]  = '{8,  13'd199,  16'h0199, 4'b1000};
    vecs[7]  = '{13, 13'd8191, 16'h8191, 4'b0000};
    vecs[8]  = '{13, 13'd1000, 16'h1000, 4'b0000};
    vecs[9]  = '{13, 13'd9,    16'h0009, 4'b1110};
    vecs[10] = '{13, 13'd4095, 16'h4095, 4'b0000};
    vecs[11] = '{13, 13'd0,    16'h0000, 4'b1110};

    Reset = 1'b1; start8 = 1'b0; start13 = 1'b0; bin8 = '0; bin13 = '0;
    step(); step();
    chk("reset_busy", 32'(busy8), 32'd0);
    chk("reset_done", 32'(done8), 32'd0);
    chk("reset_bcd", 32'(bcd8), 32'h0);
    chk("reset_mask", 32'(mask8), 32'b1110);
    chk("reset_bcd13", 32'(bcd13), 32'h0);
    chk("reset_mask13", 32'(mask13), 32'b1110);
    Reset = 1'b0;
    step();

    for (int i = 0; i < 12; i++) begin
      run(vecs[i].w, vecs[i].v, vecs[i].bcd, vecs[i].mask, d);
      chk("latency", 32'(d - (cyc - vecs[i].w - 2)), 32'(vecs[i].w + 1));
    end

    // start held high and bin_in changed while converting
    start8 = 1'b1; bin8 = 8'd37;
    for (int k = 1; k <= 19; k++) begin
      step();
      if (k == 1) bin8 = 8'd200;
      chk("held_start_done", 32'(done8), 32'((k == 9) || (k == 19)));
      chk("held_start_busy", 32'(busy8), 32'((k <= 8) || (k >= 11 && k <= 18)));
      if (k == 9) begin
        chk("held_start_bcd1", 32'(bcd8), 32'h0037);
        chk("held_start_mask1", 32'(mask8), 32'b1100);
      end
      if (k == 11) start8 = 1'b0;
      if (k == 19) begin
        chk("held_start_bcd2", 32'(bcd8), 32'h0200);
        chk("held_start_mask2", 32'(mask8), 32'b1000);
      end
    end
    step();

    // reset in cycle 4 of a 255 conversion
    start8 = 1'b1; bin8 = 8'd255;
    step();
    start8 = 1'b0;
    step(); step(); step();
    chk("pre_reset_busy", 32'(busy8), 32'd1);
    Reset = 1'b1;
    step();
    chk("abort_busy", 32'(busy8), 32'd0);
    chk("abort_done", 32'(done8), 32'd0);
    chk("abort_bcd", 32'(bcd8), 32'h0);
    chk("abort_mask", 32'(mask8), 32'b1110);
    Reset = 1'b0;
    for (int k = 0; k < 12; k++) begin
      step();
      chk("abort_no_done", 32'(done8), 32'd0);
      chk("abort_stays_idle", 32'(busy8), 32'd0);
    end
    run(8, 13'd42, 16'h0042, 4'b1100, d);

    // back-to-back sweep of every 8-bit value
    prev = 0;
    for (int v = 0; v < 256; v++) begin
      d0 = v % 10; d1 = (v / 10) % 10; d2 = (v / 100) % 10; d3 = v / 1000;
      rb = {d3[3:0], d2[3:0], d1[3:0], d0[3:0]};
      rm[3] = (d3 == 0);
      rm[2] = rm[3] && (d2 == 0);
      rm[1] = rm[2] && (d1 == 0);
      rm[0] = 1'b0;
      run(8, 13'(v), rb, rm, d);
      if (v > 0) chk("done_spacing", 32'(d - prev), 32'd10);
      prev = d;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
